// File: rtl/display_pkg.sv
// Shared display types: default geometry, RGB pixel word and slice FSM states.
// No logic; imported by the slice scheduler and its pending-angle tracker.
package display_pkg;

    localparam int DEFAULT_ROT_RES    = 1024;
    localparam int DEFAULT_NUM_ROWS   = 64;
    localparam int DEFAULT_DATA_WIDTH = 24;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WAIT,
        PRESENT,
        DONE
    } slice_state_t;

endpackage

// File: rtl/theta_slice_scheduler_pending.sv
// Angle change detector with a one-deep pending slot; optional skip counter (THETA_SLICE_SKIP_CNT_EN).
// Latency: pending flag is set one cycle after dtheta changes.
// Backpressure: none; a newer angle overwrites an unconsumed one.
module theta_change_pending
    import display_pkg::*;
#(
    parameter int TW = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_enable,
    input  logic [TW-1:0] i_dtheta,
    input  logic          i_consume,
    output logic          o_pend_v,
    output logic [TW-1:0] o_pend_theta,
    output logic [15:0]   o_skip_count
);

    logic [TW-1:0] r_prev_theta;
    logic [TW-1:0] r_pend_theta;
    logic          r_pend_v;
    logic          w_chg;

    assign w_chg = (i_dtheta != r_prev_theta);

    // A refill in the same cycle as a consume wins, so the new angle is not lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_theta <= '0;
            r_pend_theta <= '0;
            r_pend_v     <= 1'b0;
        end else begin
            r_prev_theta <= i_dtheta;
            if (!i_enable) begin
                r_pend_v <= 1'b0;
            end else if (w_chg) begin
                r_pend_v     <= 1'b1;
                r_pend_theta <= i_dtheta;
            end else if (i_consume) begin
                r_pend_v <= 1'b0;
            end
        end
    end

`ifdef THETA_SLICE_SKIP_CNT_EN
    logic [15:0] r_skip_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_skip_cnt <= '0;
        end else if (i_enable && w_chg && r_pend_v && !i_consume && (r_skip_cnt != 16'hFFFF)) begin
            r_skip_cnt <= r_skip_cnt + 16'd1;
        end
    end

    assign o_skip_count = r_skip_cnt;
`else
    assign o_skip_count = '0;
`endif

    assign o_pend_v     = r_pend_v;
    assign o_pend_theta = r_pend_theta;

endmodule

// File: rtl/theta_slice_scheduler.sv
// Turns each dtheta change into a slice job streaming NUM_ROWS BRAM words to the LED driver.
// Latency: RD_LATENCY+2 cycles per row, 1+NUM_ROWS*(RD_LATENCY+2) from consume to done.
// Backpressure: pix_valid_out holds until pix_ready_in; skip counter via THETA_SLICE_SKIP_CNT_EN.
module theta_slice_scheduler
    import display_pkg::*;
#(
    parameter int ROTATIONAL_RES = DEFAULT_ROT_RES,
    parameter int NUM_ROWS       = DEFAULT_NUM_ROWS,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int RD_LATENCY     = 2,
    localparam int TW = $clog2(ROTATIONAL_RES),
    localparam int RW = $clog2(NUM_ROWS),
    localparam int AW = TW + RW
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  enable_in,
    input  logic [TW-1:0]         dtheta,
    output logic [AW-1:0]         rd_addr_out,
    input  logic [DATA_WIDTH-1:0] rd_data_in,
    output logic [DATA_WIDTH-1:0] pix_data_out,
    output logic [RW-1:0]         pix_row_out,
    output logic                  pix_valid_out,
    input  logic                  pix_ready_in,
    output logic                  slice_start_out,
    output logic                  slice_done_out,
    output logic                  busy_out,
    output logic [15:0]           skip_count_out
);

    localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    slice_state_t          r_state;
    logic [TW-1:0]         r_cur_theta;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_wait_cnt;
    logic [AW-1:0]         r_rd_addr;
    logic [DATA_WIDTH-1:0] r_pix_data;
    logic [RW-1:0]         r_pix_row;
    logic                  r_pix_valid;
    logic                  r_start;
    logic                  r_done;

    logic                  w_pend_v;
    logic [TW-1:0]         w_pend_theta;
    logic                  w_consume;

    assign w_consume = (r_state == IDLE) && w_pend_v && enable_in;

    theta_change_pending #(
        .TW (TW)
    ) u_pending (
        .i_clk        (clk_in),
        .i_rst        (rst_in),
        .i_enable     (enable_in),
        .i_dtheta     (dtheta),
        .i_consume    (w_consume),
        .o_pend_v     (w_pend_v),
        .o_pend_theta (w_pend_theta),
        .o_skip_count (skip_count_out)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= IDLE;
            r_cur_theta <= '0;
            r_row       <= '0;
            r_wait_cnt  <= '0;
            r_rd_addr   <= '0;
            r_pix_data  <= '0;
            r_pix_row   <= '0;
            r_pix_valid <= 1'b0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_consume) begin
                        r_cur_theta <= w_pend_theta;
                        r_row       <= '0;
                        r_start     <= 1'b1;
                        r_state     <= ADDR;
                    end
                end
                ADDR: begin
                    r_rd_addr  <= {r_cur_theta, r_row};
                    r_wait_cnt <= CW'(RD_LATENCY - 1);
                    r_state    <= WAIT;
                end
                WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_pix_data  <= rd_data_in;
                        r_pix_row   <= r_row;
                        r_pix_valid <= 1'b1;
                        r_state     <= PRESENT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                PRESENT: begin
                    if (pix_ready_in) begin
                        r_pix_valid <= 1'b0;
                        if (r_row == RW'(NUM_ROWS - 1)) begin
                            r_state <= DONE;
                        end else begin
                            r_row   <= r_row + 1'b1;
                            r_state <= ADDR;
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign rd_addr_out     = r_rd_addr;
    assign pix_data_out    = r_pix_data;
    assign pix_row_out     = r_pix_row;
    assign pix_valid_out   = r_pix_valid;
    assign slice_start_out = r_start;
    assign slice_done_out  = r_done;
    assign busy_out        = (r_state != IDLE);

endmodule

// File: tb/tb_theta_slice_scheduler.sv
// Directed bench for theta_slice_scheduler: slice job table plus hand sequences for
// skip, enable and asynchronous reset corner cases; BRAM modelled as address-tagged data.
module tb_theta_slice_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic [9:0]  dtheta;
    logic [15:0] rd_addr_out;
    logic [23:0] rd_data_in;
    logic [23:0] pix_data_out;
    logic [5:0]  pix_row_out;
    logic        pix_valid_out;
    logic        pix_ready_in;
    logic        slice_start_out;
    logic        slice_done_out;
    logic        busy_out;
    logic [15:0] skip_count_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    theta_slice_scheduler dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .dtheta          (dtheta),
        .rd_addr_out     (rd_addr_out),
        .rd_data_in      (rd_data_in),
        .pix_data_out    (pix_data_out),
        .pix_row_out     (pix_row_out),
        .pix_valid_out   (pix_valid_out),
        .pix_ready_in    (pix_ready_in),
        .slice_start_out (slice_start_out),
        .slice_done_out  (slice_done_out),
        .busy_out        (busy_out),
        .skip_count_out  (skip_count_out)
    );

    function automatic logic [23:0] pix_of(input logic [15:0] a);
        return {a ^ 16'h5A5A, 8'hC3};
    endfunction

    // Two-cycle BRAM: one address register, then combinational lookup.
    logic [15:0] bram_addr_q = '0;
    always @(posedge clk_in) bram_addr_q <= rd_addr_out;
    assign rd_data_in = pix_of(bram_addr_q);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  theta;
        bit          rnd_ready;
        bit          chk_lat;
        logic [15:0] exp_base;
    } vec_t;

    vec_t vecs[4];

    task automatic run_job(input logic [9:0] th, input bit rnd, input bit chk_lat,
                           input logic [15:0] base);
        int          hs;
        int          cyc;
        bit          seen_start;
        bit          seen_done;
        bit          hold;
        logic [23:0] hd;
        logic [5:0]  hr;
        dtheta = th;
        pix_ready_in = 1'b1;
        seen_start = 1'b0;
        for (int i = 0; i < 20 && !seen_start; i++) begin
            @(negedge clk_in);
            if (slice_start_out) seen_start = 1'b1;
        end
        chk("job_start", {31'd0, seen_start}, 32'd1);
        if (!seen_start) return;
        chk("busy_at_start", {31'd0, busy_out}, 32'd1);
        hs = 0;
        cyc = 0;
        hold = 1'b0;
        hd = '0;
        hr = '0;
        seen_done = 1'b0;
        pix_ready_in = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
        while (!seen_done && cyc < 3000) begin
            @(negedge clk_in);
            cyc++;
            if (slice_done_out) begin
                seen_done = 1'b1;
            end else begin
                if (hold) begin
                    chk("hold_valid", {31'd0, pix_valid_out}, 32'd1);
                    chk("hold_data", {8'd0, pix_data_out}, {8'd0, hd});
                    chk("hold_row", {26'd0, pix_row_out}, {26'd0, hr});
                end
                pix_ready_in = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
                if (pix_valid_out && pix_ready_in) begin
                    chk("row", {26'd0, pix_row_out}, hs);
                    chk("addr", {16'd0, rd_addr_out}, {16'd0, base + 16'(hs)});
                    chk("data", {8'd0, pix_data_out}, {8'd0, pix_of(base + 16'(hs))});
                    hs++;
                end
                hold = pix_valid_out && !pix_ready_in;
                hd = pix_data_out;
                hr = pix_row_out;
            end
        end
        chk("job_done", {31'd0, seen_done}, 32'd1);
        chk("handshakes", hs, 64);
        if (chk_lat) chk("latency", cyc, 257);
        pix_ready_in = 1'b1;
    endtask

    initial begin
        int          starts;
        int          busy_cnt;
        int          nz_cnt;
        bit          got;
        logic [15:0] exp_skip;

        vecs[0] = '{theta: 10'd5,    rnd_ready: 1'b0, chk_lat: 1'b1, exp_base: 16'd320};
        vecs[1] = '{theta: 10'd17,   rnd_ready: 1'b1, chk_lat: 1'b0, exp_base: 16'd1088};
        vecs[2] = '{theta: 10'd1023, rnd_ready: 1'b0, chk_lat: 1'b1, exp_base: 16'd65472};
        vecs[3] = '{theta: 10'd0,    rnd_ready: 1'b0, chk_lat: 1'b1, exp_base: 16'd0};
`ifdef THETA_SLICE_SKIP_CNT_EN
        exp_skip = 16'd1;
`else
        exp_skip = 16'd0;
`endif

        rst_in = 1'b1;
        enable_in = 1'b1;
        dtheta = '0;
        pix_ready_in = 1'b1;
        #23;
        chk("rst_addr", {16'd0, rd_addr_out}, 32'd0);
        chk("rst_valid", {31'd0, pix_valid_out}, 32'd0);
        chk("rst_busy", {31'd0, busy_out}, 32'd0);
        chk("rst_skip", {16'd0, skip_count_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // dtheta held at zero must never launch a job.
        starts = 0;
        busy_cnt = 0;
        nz_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_in);
            if (slice_start_out) starts++;
            if (busy_out) busy_cnt++;
            if (pix_valid_out || slice_done_out || rd_addr_out != 0 || pix_data_out != 0 ||
                pix_row_out != 0 || skip_count_out != 0) nz_cnt++;
        end
        chk("idle_starts", starts, 0);
        chk("idle_busy", busy_cnt, 0);
        chk("idle_outputs", nz_cnt, 0);

        for (int v = 0; v < 4; v++) begin
            run_job(vecs[v].theta, vecs[v].rnd_ready, vecs[v].chk_lat, vecs[v].exp_base);
            repeat (5) @(negedge clk_in);
        end
        chk("skip_after_table", {16'd0, skip_count_out}, 32'd0);

        // 7 -> 8 -> 9 during the job for 7: 8 is overwritten, 9 runs next.
        fork
            run_job(10'd7, 1'b0, 1'b1, 16'd448);
            begin
                repeat (10) @(negedge clk_in);
                dtheta = 10'd8;
                repeat (10) @(negedge clk_in);
                dtheta = 10'd9;
            end
        join
        run_job(10'd9, 1'b0, 1'b1, 16'd576);
        chk("skip_count", {16'd0, skip_count_out}, {16'd0, exp_skip});
        repeat (5) @(negedge clk_in);

        // Disabling mid-job lets the job finish and blocks further jobs.
        fork
            run_job(10'd40, 1'b0, 1'b1, 16'd2560);
            begin
                repeat (20) @(negedge clk_in);
                enable_in = 1'b0;
                repeat (5) @(negedge clk_in);
                dtheta = 10'd41;
            end
        join
        starts = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_in);
            if (slice_start_out) starts++;
        end
        chk("disabled_starts", starts, 0);
        enable_in = 1'b1;
        repeat (5) @(negedge clk_in);

        // Async reset while a word is being presented.
        dtheta = 10'd50;
        pix_ready_in = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk_in);
            if (pix_valid_out) got = 1'b1;
        end
        chk("rst_test_valid", {31'd0, got}, 32'd1);
        #1;
        rst_in = 1'b1;
        #1;
        chk("arst_valid", {31'd0, pix_valid_out}, 32'd0);
        chk("arst_data", {8'd0, pix_data_out}, 32'd0);
        chk("arst_row", {26'd0, pix_row_out}, 32'd0);
        chk("arst_addr", {16'd0, rd_addr_out}, 32'd0);
        chk("arst_busy", {31'd0, busy_out}, 32'd0);
        chk("arst_skip", {16'd0, skip_count_out}, 32'd0);
        dtheta = '0;
        pix_ready_in = 1'b1;
        nz_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            if (slice_done_out || slice_start_out || busy_out) nz_cnt++;
        end
        rst_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            if (slice_done_out || slice_start_out || busy_out) nz_cnt++;
        end
        chk("arst_quiet", nz_cnt, 0);
        run_job(10'd51, 1'b0, 1'b1, 16'd3264);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
